// File: rtl/block_dev_seq.sv
// Multi-sector DMA sequencer: issues one block-device command per sector and
// moves every sector word-by-word between the device and a simple memory port.
module block_dev_seq #(
   parameter int WORDS_PER_SECTOR = 256,
   parameter int TIMEOUT          = 1048576
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [23:0] req_lba,
   input  logic [7:0]  req_count,
   input  logic [21:0] req_mem_addr,
   output logic        done,
   output logic        err,
   output logic [7:0]  err_sector,
   output logic [1:0]  bd_cmd,
   output logic        bd_start,
   input  logic        bd_bsy,
   input  logic        bd_rdy,
   input  logic        bd_err,
   output logic [23:0] bd_addr,
   output logic [15:0] bd_data_in,
   input  logic [15:0] bd_data_out,
   output logic        bd_rd,
   output logic        bd_wr,
   input  logic        bd_iordy,
   output logic [21:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic [3:0]  fsm_state
);

   localparam int WCW = $clog2(WORDS_PER_SECTOR);
   localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;

   typedef enum logic [3:0] {
      IDLE, CMD, WAIT_RDY, RD_DEV, WR_MEM, RD_MEM, WR_DEV, WAIT_IDLE, FINISH, FAIL
   } state_t;

   // Handshakes: a word moves on the device side in a cycle where bd_rd/bd_wr=1
   // and bd_iordy=1, and on the memory side where mem_rd/mem_wr=1 and mem_ack=1;
   // strobes, addresses and data stay constant until that cycle.
   state_t           state, state_next;
   logic             is_write;
   logic [23:0]      lba;
   logic [21:0]      addr;
   logic [8:0]       remaining;
   logic [WCW-1:0]   word_cnt;
   logic [15:0]      data;
   logic [TW-1:0]    tmo_cnt;
   logic             err_q;
   logic [7:0]       err_sec_q;
   logic             last_word, tmo_hit, active, abort;

   assign last_word = (word_cnt == WCW'(WORDS_PER_SECTOR - 1));
   assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT - 1));
   assign active    = (state != IDLE) && (state != FINISH) && (state != FAIL);
   assign abort     = active && (bd_err || tmo_hit);

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      bd_start   = 1'b0;
      bd_cmd     = 2'b00;
      bd_rd      = 1'b0;
      bd_wr      = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = CMD;
         end
         CMD: begin
            if (!bd_bsy && !abort) begin
               bd_start   = 1'b1;
               bd_cmd     = is_write ? 2'b10 : 2'b01;
               state_next = WAIT_RDY;
            end
         end
         WAIT_RDY: if (bd_rdy) state_next = is_write ? RD_MEM : RD_DEV;
         RD_DEV: begin
            bd_rd = 1'b1;
            if (bd_iordy) state_next = WR_MEM;
         end
         WR_MEM: begin
            mem_wr = 1'b1;
            if (mem_ack) state_next = last_word ? WAIT_IDLE : RD_DEV;
         end
         RD_MEM: begin
            mem_rd = 1'b1;
            if (mem_ack) state_next = WR_DEV;
         end
         WR_DEV: begin
            bd_wr = 1'b1;
            if (bd_iordy) state_next = last_word ? WAIT_IDLE : RD_MEM;
         end
         WAIT_IDLE: if (!bd_bsy) state_next = (remaining == 9'd1) ? FINISH : CMD;
         FINISH: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         FAIL: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (abort) state_next = FAIL;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         is_write  <= 1'b0;
         lba       <= '0;
         addr      <= '0;
         remaining <= '0;
         word_cnt  <= '0;
         data      <= '0;
         tmo_cnt   <= '0;
         err_q     <= 1'b0;
         err_sec_q <= '0;
      end else begin
         state   <= state_next;
         tmo_cnt <= (state_next != state) ? '0 : tmo_cnt + TW'(1);
         if (state_next == FAIL) err_q <= 1'b1;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  is_write  <= req_write;
                  lba       <= req_lba;
                  addr      <= req_mem_addr;
                  remaining <= {req_count == 8'd0, req_count};
                  err_q     <= 1'b0;
                  err_sec_q <= '0;
               end
            end
            WAIT_RDY: word_cnt <= '0;
            RD_DEV:   if (bd_iordy) data <= bd_data_out;
            RD_MEM:   if (mem_ack) data <= mem_rdata;
            WR_MEM: begin
               if (mem_ack) begin
                  addr     <= addr + 22'd1;
                  word_cnt <= word_cnt + WCW'(1);
               end
            end
            WR_DEV: begin
               if (bd_iordy) begin
                  addr     <= addr + 22'd1;
                  word_cnt <= word_cnt + WCW'(1);
               end
            end
            // A sector only counts as complete once the device has gone idle cleanly.
            WAIT_IDLE: begin
               if (!bd_bsy && state_next != FAIL) begin
                  err_sec_q <= err_sec_q + 8'd1;
                  lba       <= lba + 24'd1;
                  remaining <= remaining - 9'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign err        = err_q;
   assign err_sector = err_sec_q;
   assign bd_addr    = lba;
   assign mem_addr   = addr;
   assign bd_data_in = data;
   assign mem_wdata  = data;
   assign fsm_state  = state;

endmodule

// File: tb/tb_block_dev_seq.sv
// Bench for block_dev_seq: device/memory responders, a negedge monitor that
// pops expected commands, words and completions, and directed request tasks.
module tb_block_dev_seq;

   localparam int WPS = 4;
   localparam int TMO = 64;

   logic        clk = 1'b0, reset = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [23:0] req_lba = '0;
   logic [7:0]  req_count = '0;
   logic [21:0] req_mem_addr = '0;
   logic        done, err;
   logic [7:0]  err_sector;
   logic [1:0]  bd_cmd;
   logic        bd_start, bd_rd, bd_wr, mem_rd, mem_wr;
   logic        bd_bsy = 1'b0, bd_rdy = 1'b0, bd_err = 1'b0, bd_iordy = 1'b0, mem_ack = 1'b0;
   logic [23:0] bd_addr;
   logic [15:0] bd_data_in, mem_wdata;
   logic [15:0] bd_data_out = '0, mem_rdata = '0;
   logic [21:0] mem_addr;
   logic [3:0]  fsm_state;

   int checks = 0, failures = 0;
   logic [37:0] exp_mem_q[$];
   logic [15:0] exp_dev_q[$];
   logic [25:0] exp_cmd_q[$];
   logic [8:0]  exp_done_q[$];

   bit throttle = 0, rdy_en = 1, mem_hold = 0;
   int err_on_start = 0, n_starts = 0;
   int done_cnt = 0, cyc = 0, acc_cyc = 0, start_cyc = 0, done_cyc = 0;

   block_dev_seq #(.WORDS_PER_SECTOR(WPS), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_lba(req_lba), .req_count(req_count),
      .req_mem_addr(req_mem_addr), .done(done), .err(err), .err_sector(err_sector),
      .bd_cmd(bd_cmd), .bd_start(bd_start), .bd_bsy(bd_bsy), .bd_rdy(bd_rdy),
      .bd_err(bd_err), .bd_addr(bd_addr), .bd_data_in(bd_data_in),
      .bd_data_out(bd_data_out), .bd_rd(bd_rd), .bd_wr(bd_wr), .bd_iordy(bd_iordy),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .fsm_state(fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [15:0] dpat(input logic [23:0] l, input int w);
      logic [7:0] wb;
      wb = 8'(w);
      return {l[7:0], wb} ^ 16'h5A3C;
   endfunction

   function automatic logic [15:0] mpat(input logic [21:0] a);
      return a[15:0] ^ 16'hC3A5;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // device and memory responders
   logic        s_start, s_rd, s_wr, s_mrd, s_mwr;
   logic [23:0] s_addr, dev_lba = '0;
   logic [21:0] s_maddr;
   int dev_word = 0, dev_stall = -1, mem_stall = -1, rdy_wait = 0, idle_wait = 0;
   bit pending_start = 0;

   always @(negedge clk) begin
      s_start = bd_start; s_rd = bd_rd; s_wr = bd_wr; s_mrd = mem_rd; s_mwr = mem_wr;
      s_addr = bd_addr; s_maddr = mem_addr;
      bd_err = 1'b0;
      if (reset || req_ready) begin
         bd_bsy = 1'b0; bd_rdy = 1'b0; bd_iordy = 1'b0; mem_ack = 1'b0;
         pending_start = 0; rdy_wait = 0; idle_wait = 0; dev_stall = -1; mem_stall = -1;
      end else begin
         bd_iordy = 1'b0;
         if (s_rd || s_wr) begin
            if (dev_stall < 0) dev_stall = throttle ? int'($urandom_range(5, 1)) : 0;
            if (dev_stall == 0) begin
               bd_iordy = 1'b1;
               dev_stall = -1;
               bd_data_out = dpat(dev_lba, dev_word);
               dev_word++;
               if (dev_word == WPS) begin bd_rdy = 1'b0; idle_wait = 2; end
            end else dev_stall--;
         end
         if (idle_wait > 0) begin
            idle_wait--;
            if (idle_wait == 0) bd_bsy = 1'b0;
         end
         if (pending_start) begin
            pending_start = 0; bd_bsy = 1'b1; rdy_wait = 2;
         end else if (rdy_wait > 0) begin
            rdy_wait--;
            if (rdy_wait == 0) begin
               if (n_starts == err_on_start) begin bd_err = 1'b1; bd_bsy = 1'b0; end
               else bd_rdy = rdy_en;
            end
         end
         if (s_start) begin
            pending_start = 1; dev_lba = s_addr; dev_word = 0; n_starts++;
         end
         mem_ack = 1'b0;
         if ((s_mrd || s_mwr) && !mem_hold) begin
            if (mem_stall < 0) mem_stall = throttle ? int'($urandom_range(5, 1)) : 0;
            if (mem_stall == 0) begin
               mem_ack = 1'b1;
               mem_stall = -1;
               if (s_mrd) mem_rdata = mpat(s_maddr);
            end else mem_stall--;
         end
      end
   end

   // scoreboard monitor
   bit p_mwr = 0, p_mrd = 0, p_rd = 0, p_wr = 0;
   logic [37:0] p_mw;
   logic [21:0] p_ma;
   logic [15:0] p_wd;

   always @(negedge clk) begin
      #1;
      cyc++;
      if (reset) begin
         p_mwr = 0; p_mrd = 0; p_rd = 0; p_wr = 0;
      end else begin
         if (req_valid && req_ready) acc_cyc = cyc;
         if (bd_start) begin
            start_cyc = cyc;
            if (exp_cmd_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL bd_start: got cmd=%0h addr=%0h, none expected", bd_cmd, bd_addr);
            end else check("bd_start", {bd_cmd, bd_addr}, exp_cmd_q.pop_front());
         end
         if (mem_wr && mem_ack) begin
            if (exp_mem_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL mem_wr: got addr=%0h data=%0h, none expected", mem_addr, mem_wdata);
            end else check("mem_wr", {mem_addr, mem_wdata}, exp_mem_q.pop_front());
         end
         if (bd_wr && bd_iordy) begin
            if (exp_dev_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL bd_wr: got data=%0h, none expected", bd_data_in);
            end else check("bd_wr", bd_data_in, exp_dev_q.pop_front());
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_done_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL done: got err=%0d err_sector=%0d, no done expected", err, err_sector);
            end else check("done_err", {err, err_sector}, exp_done_q.pop_front());
         end
         if (bd_rd || bd_wr || mem_rd || mem_wr)
            check("one_in_flight", (bd_rd | bd_wr) & (mem_rd | mem_wr), 0);
         if (p_mwr) check("mem_wr_hold", {mem_wr, mem_addr, mem_wdata}, {1'b1, p_mw});
         if (p_mrd) check("mem_rd_hold", {mem_rd, mem_addr}, {1'b1, p_ma});
         if (p_rd)  check("bd_rd_hold", bd_rd, 1);
         if (p_wr)  check("bd_wr_hold", {bd_wr, bd_data_in}, {1'b1, p_wd});
         p_mwr = mem_wr && !mem_ack; p_mw = {mem_addr, mem_wdata};
         p_mrd = mem_rd && !mem_ack; p_ma = mem_addr;
         p_rd  = bd_rd && !bd_iordy;
         p_wr  = bd_wr && !bd_iordy; p_wd = bd_data_in;
      end
   end

   // driver tasks
   task automatic push_exp(input bit wr, input logic [23:0] lba, input logic [21:0] ma,
                           input int n_cmd, input int n_data, input bit e, input logic [7:0] esec);
      logic [23:0] l;
      logic [21:0] a;
      for (int s = 0; s < n_cmd; s++) begin
         l = lba + 24'(s);
         exp_cmd_q.push_back({wr ? 2'b10 : 2'b01, l});
      end
      for (int s = 0; s < n_data; s++) begin
         for (int w = 0; w < WPS; w++) begin
            a = ma + 22'(s * WPS + w);
            l = lba + 24'(s);
            if (wr) exp_dev_q.push_back(mpat(a));
            else    exp_mem_q.push_back({a, dpat(l, w)});
         end
      end
      exp_done_q.push_back({e, esec});
   endtask

   task automatic send_req(input bit wr, input logic [23:0] lba, input logic [7:0] cnt,
                           input logic [21:0] ma);
      int n = 0;
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
      req_valid = 1'b1; req_write = wr; req_lba = lba; req_count = cnt; req_mem_addr = ma;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic clear_exp();
      exp_cmd_q.delete(); exp_mem_q.delete(); exp_dev_q.delete(); exp_done_q.delete();
   endtask

   task automatic wait_done(input string name, input int budget);
      int start = done_cnt;
      int n = 0;
      while (done_cnt == start && n < budget) begin @(negedge clk); #2; n++; end
      if (done_cnt == start) begin
         checks++; failures++;
         $display("FAIL %s: no done within %0d cycles", name, budget);
      end
      repeat (2) @(negedge clk);
      check({name, "_drain"},
            exp_cmd_q.size() + exp_mem_q.size() + exp_dev_q.size() + exp_done_q.size(), 0);
      clear_exp();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_req_ready"}, req_ready, 1);
      check({tag, "_strobes"}, {done, bd_start, bd_rd, bd_wr, mem_rd, mem_wr}, 0);
      check({tag, "_err"}, {err, err_sector}, 0);
      check({tag, "_bd_cmd_addr"}, {bd_cmd, bd_addr}, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_data"}, {bd_data_in, mem_wdata}, 0);
      check({tag, "_state"}, fsm_state, 0);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      #2;
      check_reset_state("rst");
      reset = 1'b0;
      @(negedge clk);

      // single-sector read, zero-wait
      push_exp(0, 24'h000010, 22'h000100, 1, 1, 0, 8'd1);
      send_req(0, 24'h000010, 8'd1, 22'h000100);
      wait_done("read1", 200);
      check("req_to_start", start_cyc - acc_cyc, 1);

      // three-sector write across the LBA wrap
      push_exp(1, 24'hFFFFFF, 22'h001000, 3, 3, 0, 8'd3);
      send_req(1, 24'hFFFFFF, 8'd3, 22'h001000);
      wait_done("write3", 400);
      check("write3_mem_addr_end", mem_addr, 22'h001000 + 22'(3 * WPS));

      // throttled device and memory
      throttle = 1;
      push_exp(0, 24'h000040, 22'h000400, 2, 2, 0, 8'd2);
      send_req(0, 24'h000040, 8'd2, 22'h000400);
      wait_done("thr_read", 2000);
      push_exp(1, 24'h000080, 22'h000800, 2, 2, 0, 8'd2);
      send_req(1, 24'h000080, 8'd2, 22'h000800);
      wait_done("thr_write", 2000);
      throttle = 0;

      // device error on the second sector's command
      err_on_start = n_starts + 2;
      push_exp(0, 24'h000200, 22'h002000, 2, 1, 1, 8'd1);
      send_req(0, 24'h000200, 8'd4, 22'h002000);
      wait_done("dev_err", 400);
      check("err_sticky", {err, err_sector}, {1'b1, 8'd1});
      err_on_start = 0;
      push_exp(0, 24'h000300, 22'h003000, 1, 1, 0, 8'd1);
      send_req(0, 24'h000300, 8'd1, 22'h003000);
      #2;
      check("err_cleared", {err, err_sector}, 0);
      wait_done("after_err", 200);

      // count=0 means 256 sectors, with LBA and memory wrap
      push_exp(0, 24'hFFFF80, 22'h3FFF00, 256, 256, 0, 8'd0);
      send_req(0, 24'hFFFF80, 8'd0, 22'h3FFF00);
      wait_done("count256", 10000);

      // device never ready: timeout abort
      rdy_en = 0;
      push_exp(0, 24'h000400, 22'h000000, 1, 0, 1, 8'd0);
      send_req(0, 24'h000400, 8'd1, 22'h000000);
      wait_done("timeout", 300);
      check("timeout_latency", done_cyc - start_cyc, TMO + 1);
      rdy_en = 1;

      // reset while a memory write is stalled
      mem_hold = 1;
      push_exp(0, 24'h000500, 22'h005000, 1, 1, 0, 8'd1);
      send_req(0, 24'h000500, 8'd1, 22'h005000);
      n = 0;
      while (!mem_wr && n < 50) begin @(negedge clk); n++; end
      check("reach_wr_mem", mem_wr, 1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #2;
      check_reset_state("mid_rst");
      clear_exp();
      mem_hold = 0;
      push_exp(0, 24'h000600, 22'h006000, 1, 1, 0, 8'd1);
      send_req(0, 24'h000600, 8'd1, 22'h006000);
      wait_done("recover", 200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
